// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the 4-requester memory port arbiter.
package mem_port_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping mod 4.
module mem_port_arbiter_rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]   ptr_i,
  output logic               any_o,
  output logic [SEL_W-1:0]   idx_o
);

  // Scan from the farthest offset down so the nearest hit overwrites.
  always_comb begin
    any_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[ptr_i + SEL_W'(i)]) begin
        any_o = 1'b1;
        idx_o = ptr_i + SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux4.sv
// Generic 4:1 datapath mux; purely combinational, no flow control.
module mux4 #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [3:0][DATA_WIDTH-1:0] in_i,
  input  logic [1:0]                 sel_i,
  output logic [DATA_WIDTH-1:0]      out_o
);

  assign out_o = in_i[sel_i];

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of one memory port: req->gnt 1 cycle, grant held until mem_ready, 1-cycle done.
// Stalls indefinitely on mem_ready low; ARB_STATS_EN adds saturating per-requester completion counters.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
`ifdef ARB_STATS_EN
  , parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NUM_REQ-1:0]                 req_i,
  input  logic [NUM_REQ-1:0]                 we_i,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_i,
  output logic [NUM_REQ-1:0]                 gnt_o,
  output logic [NUM_REQ-1:0]                 done_o,
  output logic [DATA_WIDTH-1:0]              rdata_o,
  output logic [SEL_W-1:0]                   sel_o,
  output logic                               mem_valid_o,
  output logic                               mem_we_o,
  output logic [ADDR_WIDTH-1:0]              mem_addr_o,
  output logic [DATA_WIDTH-1:0]              mem_wdata_o,
  input  logic                               mem_ready_i,
  input  logic [DATA_WIDTH-1:0]              mem_rdata_i
`ifdef ARB_STATS_EN
  , output logic [NUM_REQ-1:0][CNT_WIDTH-1:0] grant_cnt_o
`endif
);

  arb_state_t           state_q;
  logic [SEL_W-1:0]     ptr_q;
  logic [SEL_W-1:0]     sel_q;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                 mem_valid_q;

  logic                 pick_any;
  logic [SEL_W-1:0]     pick_idx;

  mem_port_arbiter_rr_pick u_pick (
    .req_i (req_i),
    .ptr_i (ptr_q),
    .any_o (pick_any),
    .idx_o (pick_idx)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= '0;
          if (pick_any) begin
            sel_q       <= pick_idx;
            gnt_q       <= onehot(pick_idx);
            mem_valid_q <= 1'b1;
            state_q     <= BUSY;
          end
        end
        BUSY: begin
          // Read data is captured on writes too; the owner simply ignores it.
          if (mem_ready_i) begin
            rdata_q     <= mem_rdata_i;
            done_q      <= onehot(sel_q);
            gnt_q       <= '0;
            mem_valid_q <= 1'b0;
            ptr_q       <= sel_q + SEL_W'(1);
            state_q     <= DONE;
          end
        end
        DONE: begin
          done_q  <= '0;
          state_q <= IDLE;
        end
        default: begin
          gnt_q       <= '0;
          done_q      <= '0;
          mem_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  mux4 #(.DATA_WIDTH(ADDR_WIDTH)) u_addr_mux (
    .in_i  (addr_i),
    .sel_i (sel_q),
    .out_o (mem_addr_o)
  );

  mux4 #(.DATA_WIDTH(DATA_WIDTH)) u_wdata_mux (
    .in_i  (wdata_i),
    .sel_i (sel_q),
    .out_o (mem_wdata_o)
  );

  assign mem_we_o    = we_i[sel_q];
  assign gnt_o       = gnt_q;
  assign done_o      = done_q;
  assign rdata_o     = rdata_q;
  assign sel_o       = sel_q;
  assign mem_valid_o = mem_valid_q;

`ifdef ARB_STATS_EN
  logic [NUM_REQ-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (done_q[k] && (cnt_q[k] != {CNT_WIDTH{1'b1}})) begin
        cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule
